// File: rtl/uart_pkg.sv
// Shared UART definitions: character width, RX entry layout and FIFO width helpers.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 9;

    typedef struct packed {
        logic                   fe;
        logic                   pe;
        logic [UART_DATA_W-1:0] data;
    } uart_rx_entry_t;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: register array with one synchronous write port and a registered read port.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = UART_DATA_W + 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ptr_w(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
    input  logic [ptr_w(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]        rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the read register is reset; a same-cycle write to rd_addr returns the old entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures characters with error status on rx_available rising edges
// and serves them to the host through a pop/valid port.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ALMOST_FULL = 12,
    parameter int unsigned DATA_W      = UART_DATA_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_available,
    input  logic [DATA_W-1:0]       rx_data,
    input  logic                    rx_pe,
    input  logic                    rx_fe,
    output logic                    clear_pe,
    output logic                    clear_fe,
    input  logic                    rd_en,
    output logic                    rd_valid,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_pe,
    output logic                    rd_fe,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_full,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                    overrun,
    input  logic                    clear_overrun
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);
    localparam int unsigned EW = DATA_W + 2;

    logic          avail_q;
    logic          capture;
    logic          pop;
    logic          wr;
    logic          ovr_set;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [EW-1:0] rd_entry;

    assign empty       = (count == '0);
    assign full        = (count == CW'(DEPTH));
    assign almost_full = (count >= CW'(ALMOST_FULL));

    // A pop while full frees the slot the capture needs, so the write is still accepted.
    always_comb begin
        capture = rx_available && !avail_q;
        pop     = rd_en && !empty;
        wr      = capture && (!full || pop);
        ovr_set = capture && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            avail_q  <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overrun  <= 1'b0;
            rd_valid <= 1'b0;
            clear_pe <= 1'b0;
            clear_fe <= 1'b0;
        end else begin
            avail_q  <= rx_available;
            rd_valid <= pop;
            clear_pe <= capture && rx_pe;
            clear_fe <= capture && rx_fe;
            if (wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (wr && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !wr) begin
                count <= count - CW'(1);
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr),
        .wr_addr (wr_ptr),
        .wr_data ({rx_fe, rx_pe, rx_data}),
        .rd_en   (pop),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

    assign {rd_fe, rd_pe, rd_data} = rd_entry;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer sitting directly downstream of the UART receiver. It captures each completed character, with its parity and framing error status, on the rising edge of the receiver's character-available level. Characters are queued in a circular buffer and presented to the host through a pop/valid read port. The block also pulses the receiver's error-clear inputs once errors have been captured, and reports occupancy, almost-full and sticky overrun status.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, ≥ 2
- ALMOST_FULL, 12, `almost_full` asserts when `count` ≥ this value; range 1..DEPTH
- DATA_W, 9, character width; matches the receiver's data output

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high
- rx_available  in  1  receiver's character-available level
- rx_data  in  DATA_W  receiver's character data; bit 8 is meaningful only in 9-bit mode
- rx_pe  in  1  receiver parity-error flag
- rx_fe  in  1  receiver framing-error flag
- clear_pe  out  1  one-cycle pulse to the receiver's parity-error clear input
- clear_fe  out  1  one-cycle pulse to the receiver's framing-error clear input
- rd_en  in  1  host pop request
- rd_valid  out  1  `rd_data`, `rd_pe` and `rd_fe` are valid this cycle (one-cycle pulse)
- rd_data  out  DATA_W  popped character
- rd_pe  out  1  parity error of the popped character
- rd_fe  out  1  framing error of the popped character
- empty  out  1  `count` == 0
- full  out  1  `count` == DEPTH
- almost_full  out  1  `count` ≥ ALMOST_FULL
- count  out  $clog2(DEPTH)+1  current occupancy
- overrun  out  1  sticky: a character was dropped
- clear_overrun  in  1  clears `overrun`

## Operation
- **Capture.** `avail_q` registers `rx_available`. A capture event occurs when `rx_available` is 1 and `avail_q` is 0, i.e. on a rising edge only. A level held high produces exactly one capture.
- **Entry format.** Each entry is {fe, pe, data}, DATA_W+2 bits, sampled from the inputs in the capture cycle.
- **Write.**
  - If not full: store the entry at `wr_ptr`, and `wr_ptr` advances.
  - If full and no pop this cycle: drop the entry, and `overrun` is set.
- **Read.**
  - `rd_en` while not empty: the entry at `rd_ptr` is registered into `rd_data`, `rd_pe` and `rd_fe`; `rd_valid` is 1 the next cycle; `rd_ptr` advances.
  - `rd_en` while empty: ignored. `rd_valid` stays 0 and the read outputs hold their last values.
- **Simultaneous capture and pop.**
  - Not empty and not full: both happen; `count` is unchanged.
  - Full: the pop frees a slot and the write is accepted; `count` stays DEPTH and no overrun occurs.
  - Empty: the write happens and the pop is ignored (no fall-through); `count` goes to 1.
- **Pointers.** Both pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` is tracked separately: +1 on write only, −1 on pop only.
- **Error clear.** `clear_pe` pulses the cycle after a capture whose `rx_pe` was 1; `clear_fe` likewise for `rx_fe`. This applies whether the entry was stored or dropped.
- **Overrun.**
  - `clear_overrun` clears `overrun`.
  - If a set event and `clear_overrun` occur in the same cycle, set wins.
- **Reset** (synchronous; also applies mid-operation). Takes effect at the next clk edge; pending captures and pops in that cycle are discarded. Values after reset:
  - `wr_ptr`, `rd_ptr`, `count` = 0
  - `empty` = 1
  - `full`, `almost_full`, `overrun`, `rd_valid`, `clear_pe`, `clear_fe` = 0
  - `rd_data` = 0, `rd_pe` = 0, `rd_fe` = 0
  - `avail_q` = 1, so an `rx_available` already high at reset release is not captured.
  - Memory contents are not reset.

## Timing
- Capture to `count`, `empty` and `full` updated: 1 cycle after the clk edge that samples the rising edge.
- `rd_en` to `rd_valid`: 1 cycle. Back-to-back `rd_en` yields one entry per cycle.
- `empty`, `full`, `almost_full` and `count` are registered or derived from registered `count`; they never depend on this cycle's `rd_en` or `rx_available`.
- Capture to `clear_pe`/`clear_fe`: 1 cycle. The receiver holds `rx_available` for many cycles, so the clear lands while the character is still presented.
- Throughput: one write and one read per cycle.

## Structure
- Shared package `uart_pkg` holds:
  - `UART_DATA_W` = 9
  - typedef `uart_rx_entry_t` {fe, pe, data[8:0]}
  - the `$clog2`-derived pointer and count widths as localparam functions, shared with the TX FIFO
- Sub-module `uart_fifo_mem`: DEPTH × (DATA_W+2) register array, one synchronous write port and one registered read port. All pointer, count and flag logic stays in `uart_rx_fifo`.

## Test plan
- **Reset:** after reset, check `empty`=1, `count`=0, `overrun`=0, `rd_valid`=0. Holding `rx_available`=1 through reset release causes no capture.
- **Basic capture:** one rising edge with `rx_data`=0x0A5, `rx_pe`=1, `rx_fe`=0 gives `count`=1 and a single `clear_pe` pulse with no `clear_fe`. Then `rd_en` gives `rd_valid` the next cycle with `rd_data`=0x0A5, `rd_pe`=1, `rd_fe`=0, and `empty`=1.
- **Fill and overrun:** 16 captures of 0x000..0x00F give `full`=1, with `almost_full` going high on the 12th. A 17th capture of 0x1FF sets `overrun` and leaves `count`=16. Draining returns 0x000..0x00F in order, so pointer wrap is checked.
- **Full with simultaneous capture and pop:** the pop returns the oldest entry, the new entry is accepted, `count` stays 16 and `overrun` stays 0.
- **Empty with simultaneous capture and pop:** `rd_valid` stays 0 and `count` goes to 1. `rd_en` while empty is ignored and the outputs hold.
- **Priority and mid-operation reset:** `clear_overrun` in the same cycle as an overrun leaves `overrun`=1. Reset with `count`=5 returns all outputs to their reset values next cycle.
